ax_pwm_axil_slave: RTL and testbench

//  AXI4-Lite responder for the ax_pwm peripheral: decodes master writes/reads into a
//  4-register bank and drives one PWM output from a free-running period counter.

---
 rtl/ax_pwm_axil_slave.sv | 138 +++++++++++++
 tb/tb_ax_pwm_axil_slave.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ax_pwm_axil_slave.sv
// ax_pwm_axil_slave: AXI4-Lite slave with a 4-register bank (CTRL/PERIOD/DUTY/STATUS) driving one PWM output
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET (sync, active-high)
//   AW/W/B channel : S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, S_AXI_WDATA/WSTRB/WVALID/WREADY,
//                    S_AXI_BRESP/BVALID/BREADY
//   AR/R channel   : S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, S_AXI_RDATA/RRESP/RVALID/RREADY
//   pwm_out        : registered PWM waveform
//   irq            : period-end interrupt (tied 0 unless PWM_IRQ_EN is defined)
// Optional feature macro: PWM_IRQ_EN adds a sticky W1C wrap flag in STATUS[31] that drives irq.
module ax_pwm_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_CNT_W = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pwm_out,
  output logic                            irq
);
  logic aw_ready_q, aw_ready_d, b_valid_q, b_valid_d;
  logic ar_ready_q, ar_ready_d, r_valid_q, r_valid_d;
  logic [31:0] r_data_q, r_data_d, ctrl_q, ctrl_d, period_q, period_d, duty_q, duty_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d, per_a_q, per_a_d, duty_a_q, duty_a_d;
  logic pwm_q, pwm_d;
  logic wr_en, rd_en, en, wrap, reload;
  logic [1:0] wr_sel, rd_sel;
  logic [31:0] status, cnt_ext, rd_val;
  logic unused_ok;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = s[i] ? d[8*i+:8] : old[8*i+:8];
    return r;
  endfunction

  assign wr_en   = aw_ready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en   = ar_ready_q && S_AXI_ARVALID;
  assign wr_sel  = S_AXI_AWADDR[3:2];
  assign rd_sel  = S_AXI_ARADDR[3:2];
  assign en      = ctrl_q[0];
  assign wrap    = en && cnt_q == per_a_q;
  // shadows track the programmed values while idle so enabling starts cleanly
  assign reload  = wrap || !en;
  assign cnt_ext = 32'(cnt_q);
  assign rd_val  = rd_sel == 2'd0 ? ctrl_q : rd_sel == 2'd1 ? period_q : rd_sel == 2'd2 ? duty_q : status;

  always_comb begin
    aw_ready_d = S_AXI_AWVALID && S_AXI_WVALID && !b_valid_q && !aw_ready_q;
    b_valid_d  = b_valid_q ? !S_AXI_BREADY : wr_en;
    ar_ready_d = S_AXI_ARVALID && !r_valid_q && !ar_ready_q;
    r_valid_d  = r_valid_q ? !S_AXI_RREADY : rd_en;
    r_data_d   = rd_en ? rd_val : r_data_q;
    ctrl_d     = wr_en && wr_sel == 2'd0 ? merge(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB) : ctrl_q;
    period_d   = wr_en && wr_sel == 2'd1 ? merge(period_q, S_AXI_WDATA, S_AXI_WSTRB) : period_q;
    duty_d     = wr_en && wr_sel == 2'd2 ? merge(duty_q, S_AXI_WDATA, S_AXI_WSTRB) : duty_q;
    cnt_d      = reload ? '0 : cnt_q + C_CNT_W'(1);
    per_a_d    = reload ? period_q[C_CNT_W-1:0] : per_a_q;
    duty_a_d   = reload ? duty_q[C_CNT_W-1:0] : duty_a_q;
    pwm_d      = (en && cnt_q < duty_a_q) ^ ctrl_q[1];
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_ready_q <= 1'b0;
      b_valid_q  <= 1'b0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      ctrl_q     <= '0;
      period_q   <= '0;
      duty_q     <= '0;
      cnt_q      <= '0;
      per_a_q    <= '0;
      duty_a_q   <= '0;
      pwm_q      <= 1'b0;
    end else begin
      aw_ready_q <= aw_ready_d;
      b_valid_q  <= b_valid_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      ctrl_q     <= ctrl_d;
      period_q   <= period_d;
      duty_q     <= duty_d;
      cnt_q      <= cnt_d;
      per_a_q    <= per_a_d;
      duty_a_q   <= duty_a_d;
      pwm_q      <= pwm_d;
    end
  end

`ifdef PWM_IRQ_EN
  logic irq_q, irq_d;
  logic unused_irq;
  // a wrap in the same cycle as a W1C clear keeps the flag set
  always_comb irq_d = wrap ? 1'b1 : (wr_en && wr_sel == 2'd3 && S_AXI_WDATA[31] && S_AXI_WSTRB[3]) ? 1'b0 : irq_q;
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end
  assign status     = {irq_q, cnt_ext[30:0]};
  assign irq        = irq_q;
  assign unused_irq = cnt_ext[31];
`else
  assign status = cnt_ext;
  assign irq    = 1'b0;
`endif

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BVALID  = b_valid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = r_valid_q;
  assign S_AXI_RDATA   = r_data_q;
  assign S_AXI_RRESP   = 2'b00;
  assign pwm_out       = pwm_q;
  assign unused_ok     = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_ax_pwm_axil_slave.sv
// tb_ax_pwm_axil_slave: directed self-checking bench for ax_pwm_axil_slave
module tb_ax_pwm_axil_slave;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] awaddr = '0, araddr = '0, wstrb = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic awready, wready, bvalid, arready, rvalid, pwm_out, irq;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;

  ax_pwm_axil_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .pwm_out(pwm_out), .irq(irq)
  );

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic pulse_ok, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    if (!awready) begin
      vectors++; errors++;
      $display("FAIL aw_timeout addr=%h awready=%0b want 1 within 20 cycles", a, awready);
    end
    pulse_ok = wready;
    @(negedge clk);
    pulse_ok = pulse_ok && !awready && !wready && bvalid;
    resp = bresp;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output logic pulse_ok);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    if (!arready) begin
      vectors++; errors++;
      $display("FAIL ar_timeout addr=%h arready=%0b want 1 within 20 cycles", a, arready);
    end
    @(negedge clk);
    pulse_ok = !arready && rvalid;
    d = rdata; resp = rresp;
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic p;
    logic [1:0] r;
    axi_write(a, d, 4'hf, p, r);
  endtask

  task automatic sample(output logic [39:0] s);
    for (int j = 0; j < 40; j++) begin @(negedge clk); s[j] = pwm_out; end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0] r;
    logic p;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({awready, wready, bvalid, arready, rvalid, rdata, pwm_out, irq, bresp, rresp} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got aw=%0b w=%0b b=%0b ar=%0b r=%0b rdata=%h pwm=%0b irq=%0b want all 0",
               awready, wready, bvalid, arready, rvalid, rdata, pwm_out, irq);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r, p);
      vectors++;
      if (d !== 32'h0 || !p) begin
        errors++;
        $display("FAIL reset_read addr=%h got %h pulse_ok=%0b want 00000000 pulse_ok=1", 4'(i * 4), d, p);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic [1:0] r;
    logic p;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hf, p, r);
      vectors++;
      if (!p || r !== 2'b00) begin
        errors++;
        $display("FAIL write_hs addr=%h pulse_ok=%0b bresp=%0d want pulse_ok=1 bresp=0", 4'(i * 4), p, r);
      end
    end
    for (int i = 0; i < 3; i++) begin
      axi_read(4'(i * 4), d, r, p);
      vectors++;
      if (d !== 32'(i + 1) || r !== 2'b00 || !p) begin
        errors++;
        $display("FAIL readback addr=%h got %h rresp=%0d pulse_ok=%0b want %h rresp=0 pulse_ok=1",
                 4'(i * 4), d, r, p, 32'(i + 1));
      end
    end
    axi_read(4'hC, d, r, p);
    vectors++;
    if (d > 32'd2 || r !== 2'b00 || !p) begin
      errors++;
      $display("FAIL status_ro got %h rresp=%0d want counter value <= 2 (write of 4 ignored)", d, r);
    end
  endtask

  task automatic test_pwm();
    logic [39:0] s;
    logic [31:0] d;
    logic [1:0] r;
    logic p, ok;
    int idx;
    wr(4'h8, 32'd3);
    wr(4'h4, 32'd9);
    wr(4'h0, 32'd1);
    sample(s);
    idx = -1;
    for (int i = 1; i < 20; i++) if (idx < 0 && !s[i-1] && s[i]) idx = i;
    ok = idx > 0;
    for (int j = 0; j < 20; j++) if (idx > 0 && s[idx+j] !== (j % 10 < 3)) ok = 1'b0;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL pwm_3_of_10 samples=%h want 3 high / 7 low repeating every 10", s);
    end
    axi_read(4'hC, d, r, p);
    vectors++;
    if (d > 32'd9) begin
      errors++;
      $display("FAIL status_live got %h want <= 9", d);
    end
    wr(4'h0, 32'd3);
    sample(s);
    idx = -1;
    for (int i = 1; i < 20; i++) if (idx < 0 && s[i-1] && !s[i]) idx = i;
    ok = idx > 0;
    for (int j = 0; j < 20; j++) if (idx > 0 && s[idx+j] !== (j % 10 >= 3)) ok = 1'b0;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL pwm_inverted samples=%h want 7 high / 3 low repeating every 10", s);
    end
  endtask

  task automatic test_duty();
    logic [39:0] s;
    logic [31:0] d;
    logic [1:0] r;
    logic p;
    wr(4'h0, 32'd1);
    wr(4'h8, 32'd0);
    repeat (12) @(negedge clk);
    sample(s);
    vectors++;
    if (s !== 40'h0) begin
      errors++;
      $display("FAIL duty_zero samples=%h want 0000000000", s);
    end
    axi_write(4'h8, 32'hAABBCCDD, 4'b0010, p, r);
    axi_read(4'h8, d, r, p);
    vectors++;
    if (d !== 32'h0000CC00) begin
      errors++;
      $display("FAIL wstrb_lane got %h want 0000cc00", d);
    end
    repeat (12) @(negedge clk);
    sample(s);
    vectors++;
    if (s !== {40{1'b1}}) begin
      errors++;
      $display("FAIL duty_over_period samples=%h want ffffffffff", s);
    end
    wr(4'h4, 32'd0);
    wr(4'h8, 32'd1);
    repeat (12) @(negedge clk);
    axi_read(4'hC, d, r, p);
    vectors++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL period_zero_cnt got %h want 00000000", d);
    end
    sample(s);
    vectors++;
    if (s !== {40{1'b1}}) begin
      errors++;
      $display("FAIL period_zero_pwm samples=%h want ffffffffff", s);
    end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    logic [1:0] r;
    logic p;
    wr(4'h4, 32'd9);
    wr(4'h8, 32'd5);
    wr(4'h0, 32'd1);
    repeat (7) @(negedge clk);
    wr(4'h0, 32'd0);
    vectors++;
    if (pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL disable_pwm got %0b want 0", pwm_out);
    end
    axi_read(4'hC, d, r, p);
    vectors++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL disable_cnt got %h want 00000000", d);
    end
    wr(4'h0, 32'd2);
    vectors++;
    if (pwm_out !== 1'b1) begin
      errors++;
      $display("FAIL disable_invert got %0b want 1", pwm_out);
    end
    wr(4'h0, 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [1:0] r;
    logic p;
    int n, held, acc;
    @(negedge clk);
    awaddr = 4'h8; wdata = 32'h11; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    @(negedge clk);
    wdata = 32'h22;
    held = 0; acc = 0;
    repeat (6) begin @(negedge clk); held += int'(bvalid); acc += int'(awready | wready); end
    vectors++;
    if (held != 6 || acc != 0) begin
      errors++;
      $display("FAIL bvalid_hold bvalid_cycles=%0d accepts=%0d want 6 and 0", held, acc);
    end
    axi_read(4'h8, d, r, p);
    vectors++;
    if (d !== 32'h11 || !bvalid) begin
      errors++;
      $display("FAIL read_during_b got %h bvalid=%0b want 00000011 bvalid=1", d, bvalid);
    end
    bready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL b_handshake bvalid=%0b want 0", bvalid);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    vectors++;
    if (!awready) begin
      errors++;
      $display("FAIL second_aw awready=%0b want 1 after B handshake", awready);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    bready = 1'b0;
    axi_read(4'h8, d, r, p);
    vectors++;
    if (d !== 32'h22) begin
      errors++;
      $display("FAIL second_write got %h want 00000022", d);
    end
    @(negedge clk);
    araddr = 4'h8; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    @(negedge clk);
    arvalid = 1'b0;
    d = rdata;
    wr(4'h8, 32'h33);
    held = 0;
    repeat (3) begin @(negedge clk); if (rvalid && rdata === 32'h22) held++; end
    vectors++;
    if (held != 3 || d !== 32'h22) begin
      errors++;
      $display("FAIL rdata_stable got %h stable_cycles=%0d want 00000022 stable 3", rdata, held);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    vectors++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL r_handshake rvalid=%0b want 0", rvalid);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0] r;
    logic p;
    int n;
    @(negedge clk);
    awaddr = 4'h0; wdata = 32'h1; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(bvalid && rvalid) && n < 20);
    vectors++;
    if (!(bvalid && rvalid)) begin
      errors++;
      $display("FAIL pending_setup bvalid=%0b rvalid=%0b want 1 1", bvalid, rvalid);
    end
    rst = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop bvalid=%0b rvalid=%0b want 0 0", bvalid, rvalid);
    end
    axi_read(4'h0, d, r, p);
    vectors++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl got %h want 00000000", d);
    end
  endtask

  task automatic test_irq();
    int n;
`ifdef PWM_IRQ_EN
    logic p;
    logic [1:0] r;
    wr(4'h0, 32'd0);
    wr(4'h4, 32'd4);
    axi_write(4'hC, 32'h80000000, 4'h8, p, r);
    wr(4'h0, 32'd1);
    n = 0;
    while (!irq && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (n != 4) begin
      errors++;
      $display("FAIL irq_rise cycles=%0d irq=%0b want irq after 4 more cycles", n, irq);
    end
    axi_write(4'hC, 32'h80000000, 4'h8, p, r);
    vectors++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear irq=%0b want 0", irq);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rearm irq=%0b want 1", irq);
    end
`else
    wr(4'h4, 32'd1);
    wr(4'h0, 32'd1);
    n = 0;
    repeat (15) begin @(negedge clk); n += int'(irq); end
    vectors++;
    if (n != 0) begin
      errors++;
      $display("FAIL irq_tied irq_high_cycles=%0d want 0", n);
    end
`endif
    wr(4'h0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_regs();
    test_pwm();
    test_duty();
    test_disable();
    test_back_to_back();
    test_reset_mid();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within 500000 time units");
    $fatal(1);
  end
endmodule
